// File: rtl/burst_cycle_counter.sv
// Burst cycle counter: counts completed waveform cycles in a burst and
// produces the end-of-burst flag and accumulator run enable.
module burst_cycle_counter #(
    parameter int CNT_W = 24
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Burst_EN,
    input  logic             BAC_Reset,
    input  logic             Cycle_Tick,
    input  logic [CNT_W-1:0] Burst_Count,
    input  logic             Gated_Mode,
    input  logic             Gate_Level,
    output logic             CP_Sum,
    output logic             BAC_Action_EN,
    output logic [CNT_W-1:0] Cycle_Index,
    output logic             Busy
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] n_lat;

    // Cycle_Index doubles as the burst cycle count register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= IDLE;
            n_lat         <= '0;
            Cycle_Index   <= '0;
            CP_Sum        <= 1'b0;
            BAC_Action_EN <= 1'b0;
            Busy          <= 1'b0;
        end else if (!Burst_EN) begin
            state         <= IDLE;
            CP_Sum        <= 1'b0;
            BAC_Action_EN <= 1'b0;
            Busy          <= 1'b0;
        end else if (BAC_Reset) begin
            // Re-arm from any state; a coincident tick is dropped.
            n_lat       <= Burst_Count;
            Cycle_Index <= '0;
            CP_Sum      <= 1'b0;
            Busy        <= 1'b1;
            if (Gated_Mode && !Gate_Level) begin
                state         <= HOLD;
                BAC_Action_EN <= 1'b0;
            end else begin
                state         <= RUN;
                BAC_Action_EN <= 1'b1;
            end
        end else begin
            case (state)
                RUN: begin
                    if (Cycle_Tick) begin
                        if (Gated_Mode) begin
                            // Gate low lets the current cycle finish first.
                            Cycle_Index <= Cycle_Index + 1'b1;
                            if (!Gate_Level) begin
                                state         <= HOLD;
                                BAC_Action_EN <= 1'b0;
                            end
                        end else if (n_lat != '0 && Cycle_Index == n_lat - 1'b1) begin
                            Cycle_Index   <= n_lat;
                            state         <= DONE;
                            CP_Sum        <= 1'b1;
                            BAC_Action_EN <= 1'b0;
                            Busy          <= 1'b0;
                        end else begin
                            Cycle_Index <= Cycle_Index + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!Gated_Mode || Gate_Level) begin
                        state         <= RUN;
                        BAC_Action_EN <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE wait for BAC_Reset; ticks are ignored.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_cycle_counter.sv
// Directed self-checking bench for burst_cycle_counter (CNT_W=4 so wrap is reachable).
module tb_burst_cycle_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         burst_en;
    logic         bac_reset;
    logic         tick;
    logic [W-1:0] burst_count;
    logic         gated;
    logic         gate;
    logic         cp_sum;
    logic         act_en;
    logic [W-1:0] idx;
    logic         busy;

    int compared   = 0;
    int mismatched = 0;

    burst_cycle_counter #(.CNT_W(W)) dut (
        .Clock        (clk),
        .Reset        (rst),
        .Burst_EN     (burst_en),
        .BAC_Reset    (bac_reset),
        .Cycle_Tick   (tick),
        .Burst_Count  (burst_count),
        .Gated_Mode   (gated),
        .Gate_Level   (gate),
        .CP_Sum       (cp_sum),
        .BAC_Action_EN(act_en),
        .Cycle_Index  (idx),
        .Busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_arm();
        bac_reset = 1'b1;
        step();
        bac_reset = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    initial begin
        rst = 1'b1; burst_en = 1'b0; bac_reset = 1'b0; tick = 1'b0;
        burst_count = '0; gated = 1'b0; gate = 1'b1;
        step(); step();
        chk("rst_cp", cp_sum, 0);
        chk("rst_en", act_en, 0);
        chk("rst_idx", idx, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // N=3 burst, idle ticks ignored
        burst_en = 1'b1; burst_count = 4'd3;
        step();
        pulse_tick();
        chk("idle_tick_idx", idx, 0);
        chk("idle_busy", busy, 0);
        pulse_arm();
        chk("arm_en", act_en, 1);
        chk("arm_busy", busy, 1);
        chk("arm_idx", idx, 0);
        repeat (4) step();
        pulse_tick();
        chk("n3_idx1", idx, 1);
        burst_count = 4'd1;          // must not affect the running burst
        repeat (3) step();
        pulse_tick();
        chk("n3_idx2", idx, 2);
        chk("n3_cp_mid", cp_sum, 0);
        repeat (3) step();
        pulse_tick();
        chk("n3_idx3", idx, 3);
        chk("n3_cp", cp_sum, 1);
        chk("n3_en", act_en, 0);
        chk("n3_busy", busy, 0);
        for (int i = 0; i < 20; i++) begin
            if (i % 5 == 0) tick = 1'b1;
            step();
            tick = 1'b0;
        end
        chk("done_hold_cp", cp_sum, 1);
        chk("done_hold_idx", idx, 3);
        chk("done_hold_en", act_en, 0);

        // N=1, then re-arm
        pulse_arm();
        chk("n1_arm_cp", cp_sum, 0);
        chk("n1_arm_en", act_en, 1);
        pulse_tick();
        chk("n1_cp", cp_sum, 1);
        chk("n1_idx", idx, 1);
        pulse_arm();
        chk("rearm_cp", cp_sum, 0);
        chk("rearm_idx", idx, 0);
        chk("rearm_en", act_en, 1);

        // BAC_Reset coinciding with final tick
        burst_count = 4'd2;
        pulse_arm();
        pulse_tick();
        chk("coin_pre_idx", idx, 1);
        bac_reset = 1'b1; tick = 1'b1;
        step();
        bac_reset = 1'b0; tick = 1'b0;
        chk("coin_idx", idx, 0);
        chk("coin_cp", cp_sum, 0);
        chk("coin_en", act_en, 1);
        step();
        chk("coin_cp2", cp_sum, 0);

        // Infinite burst wraps
        burst_count = 4'd0;
        pulse_arm();
        repeat (14) pulse_tick();
        chk("inf_idx14", idx, 14);
        pulse_tick();
        chk("inf_idx15", idx, 15);
        pulse_tick();
        chk("inf_wrap_idx", idx, 0);
        chk("inf_cp", cp_sum, 0);
        chk("inf_en", act_en, 1);

        // Gated mode
        gated = 1'b1; gate = 1'b1;
        pulse_arm();
        chk("g_arm_en", act_en, 1);
        pulse_tick();
        chk("g_idx1", idx, 1);
        gate = 1'b0;
        step();
        chk("g_low_en", act_en, 1);
        step();
        pulse_tick();
        chk("g_hold_idx", idx, 2);
        chk("g_hold_en", act_en, 0);
        chk("g_hold_busy", busy, 1);
        pulse_tick();
        chk("g_hold_tick_idx", idx, 2);
        gate = 1'b1;
        step();
        chk("g_resume_en", act_en, 1);
        gate = 1'b0;
        step();
        gate = 1'b1;
        step();
        pulse_tick();
        chk("g_glitch_en", act_en, 1);
        chk("g_glitch_idx", idx, 3);

        // Arm into HOLD, then leave gated mode
        gate = 1'b0;
        pulse_arm();
        chk("g_armhold_en", act_en, 0);
        chk("g_armhold_busy", busy, 1);
        gated = 1'b0;
        step();
        chk("mode10_en", act_en, 1);
        gated = 1'b1;
        pulse_tick();
        chk("mode01_en", act_en, 0);
        chk("mode01_idx", idx, 1);

        // Burst_EN dropped mid-RUN
        gated = 1'b0; gate = 1'b1; burst_count = 4'd5;
        pulse_arm();
        pulse_tick();
        burst_en = 1'b0;
        step();
        chk("drop_en", act_en, 0);
        chk("drop_busy", busy, 0);
        chk("drop_idx", idx, 1);
        burst_en = 1'b1;
        pulse_tick();
        chk("drop_idle_busy", busy, 0);
        chk("drop_idle_idx", idx, 1);

        // Reset in DONE
        burst_count = 4'd1;
        pulse_arm();
        pulse_tick();
        chk("pre_rst_cp", cp_sum, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("done_rst_cp", cp_sum, 0);
        chk("done_rst_idx", idx, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
